// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: make-code decode with break/extended prefix tracking.
// Pulses register one cycle after the stop-bit falling edge; there is no backpressure, so the consumer must take each pulse as it comes.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] ps2_data_o,
  output logic       ps2_valid_o,
  output logic       ps2_done_o,
  output logic       ps2_reset_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic          fall;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    data_q, data_d;
  logic          valid_d, done_d, reset_d, err_d;

  // Synchronizers idle at 1 so reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_i;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    to_cnt_d  = to_cnt_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    reset_d   = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d   = {dat_s2, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shreg_q, dat_s2};
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (par_ok_q && dat_s2) begin
            // Prefix bytes only arm flags; a byte after F0 is a release.
            if (shreg_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (shreg_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (brk_q) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
              ext_d   = 1'b0;
              done_d  = !ext_q && (shreg_q == 8'h5A);
              reset_d = !ext_q && (shreg_q == 8'h76);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        bit_cnt_d = 3'd0;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      data_q      <= 8'd0;
      ps2_valid_o <= 1'b0;
      ps2_done_o  <= 1'b0;
      ps2_reset_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      data_q      <= data_d;
      ps2_valid_o <= valid_d;
      ps2_done_o  <= done_d;
      ps2_reset_o <= reset_d;
      err_o       <= err_d;
    end
  end

  assign ps2_data_o = data_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: bit-banged PS/2 frames, pulse counters sampled on the falling clk edge.
module tb_ps2_rx;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_dat_i = 1'b1;
  logic [7:0] ps2_data_o;
  logic       ps2_valid_o, ps2_done_o, ps2_reset_o, err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int v_cnt = 0, d_cnt = 0, r_cnt = 0, e_cnt = 0, both_cnt = 0;
  int v0, d0, r0, e0;

  ps2_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_data_o(ps2_data_o), .ps2_valid_o(ps2_valid_o), .ps2_done_o(ps2_done_o),
    .ps2_reset_o(ps2_reset_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Counting high cycles, so a stretched pulse shows up as a count above 1.
  always @(negedge clk) begin
    if (rst) begin
      if (ps2_valid_o) v_cnt++;
      if (ps2_done_o)  d_cnt++;
      if (ps2_reset_o) r_cnt++;
      if (err_o)       e_cnt++;
      if (ps2_valid_o && err_o) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = v_cnt; d0 = d_cnt; r0 = r_cnt; e0 = e_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat_i = b;
    repeat (HALF) @(posedge clk);
    ps2_clk_i = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic par;
    par = ~(^b) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    repeat (30) @(posedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_data",  {24'd0, ps2_data_o}, 32'h0);
    check("rst_valid", {31'd0, ps2_valid_o}, 32'h0);
    check("rst_done",  {31'd0, ps2_done_o},  32'h0);
    check("rst_reset", {31'd0, ps2_reset_o}, 32'h0);
    check("rst_err",   {31'd0, err_o},       32'h0);
    @(posedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);

    snap();
    send_frame(8'h1C, 1'b0);
    check("1c_data",  {24'd0, ps2_data_o}, 32'h1C);
    check("1c_valid", v_cnt - v0, 1);
    check("1c_err",   e_cnt - e0, 0);

    snap();
    send_frame(8'h5A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check("rel_valid", v_cnt - v0, 1);
    check("rel_done",  d_cnt - d0, 1);
    check("rel_data",  {24'd0, ps2_data_o}, 32'h5A);
    check("rel_err",   e_cnt - e0, 0);

    snap();
    send_frame(8'h76, 1'b1);
    check("par_err",   e_cnt - e0, 1);
    check("par_valid", v_cnt - v0, 0);
    check("par_data",  {24'd0, ps2_data_o}, 32'h5A);
    snap();
    send_frame(8'h76, 1'b0);
    check("esc_valid", v_cnt - v0, 1);
    check("esc_reset", r_cnt - r0, 1);
    check("esc_data",  {24'd0, ps2_data_o}, 32'h76);

    snap();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check("ext_valid", v_cnt - v0, 1);
    check("ext_done",  d_cnt - d0, 0);
    check("ext_data",  {24'd0, ps2_data_o}, 32'h5A);

    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TO + 100) @(posedge clk);
    check("to_err",   e_cnt - e0, 1);
    check("to_valid", v_cnt - v0, 0);
    snap();
    send_frame(8'h29, 1'b0);
    check("to_next_data",  {24'd0, ps2_data_o}, 32'h29);
    check("to_next_valid", v_cnt - v0, 1);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(posedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_data", {24'd0, ps2_data_o}, 32'h0);
    @(posedge clk); rst = 1'b1;
    repeat (TO + 100) @(posedge clk);
    check("mid_rst_valid", v_cnt - v0, 0);
    check("mid_rst_err",   e_cnt - e0, 0);
    snap();
    send_frame(8'h45, 1'b0);
    check("post_rst_data",  {24'd0, ps2_data_o}, 32'h45);
    check("post_rst_valid", v_cnt - v0, 1);
    check("post_rst_err",   e_cnt - e0, 0);

    check("valid_err_overlap", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
